// File: rtl/mem_port_arbiter.sv
// Per-port round-robin arbiter sharing four sync-RAM ports among NUM_REQ requesters.
// Optional per-port conflict counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [2*NUM_REQ-1:0]          req_port,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic [4*ADDR_WIDTH-1:0]       mem_addr,
  output logic [3:0]                    mem_wr_en,
  output logic [4*DATA_WIDTH-1:0]       mem_wr_data,
  input  logic [4*DATA_WIDTH-1:0]       mem_rd_data,
  input  logic                          perf_clr,
  output logic [4*16-1:0]               perf_cnt
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] cand [4];
  logic [PW-1:0]      rr_ptr [4];
  logic [3:0]         win_valid;
  logic [PW-1:0]      win_idx [4];
  logic [PW-1:0]      scan_idx;
  logic               take;
  logic [1:0]         rsp_port [NUM_REQ];

  // Candidate set of each port
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand[p][i] = req_valid[i] & (req_port[2*i +: 2] == 2'(p));
      end
    end
  end

  // First candidate at or after rr_ptr, scanning upward with wrap
  always_comb begin
    scan_idx = '0;
    take     = 1'b0;
    for (int p = 0; p < 4; p++) begin
      win_valid[p] = 1'b0;
      win_idx[p]   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx     = rr_ptr[p] + PW'(k);
        take         = ~win_valid[p] & cand[p][scan_idx];
        win_idx[p]   = take ? scan_idx : win_idx[p];
        win_valid[p] = win_valid[p] | take;
      end
    end
  end

  // A requester is granted when it is the winner of the port it targets
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_grant[i] = req_valid[i]
                   & win_valid[req_port[2*i +: 2]]
                   & (win_idx[req_port[2*i +: 2]] == PW'(i));
    end
  end

  // Memory-side mux; idle ports drive zeros
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 4'b0000;
    mem_wr_data = '0;
    for (int p = 0; p < 4; p++) begin
      if (win_valid[p]) begin
        mem_addr[p*ADDR_WIDTH +: ADDR_WIDTH]    = req_addr[int'(win_idx[p])*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wr_data[p*DATA_WIDTH +: DATA_WIDTH] = req_wdata[int'(win_idx[p])*DATA_WIDTH +: DATA_WIDTH];
        mem_wr_en[p]                            = req_we[win_idx[p]];
      end else begin
        mem_wr_en[p] = 1'b0;
      end
    end
  end

  // Round-robin pointers and the one-deep read response pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        rr_ptr[p] <= '0;
      end
      rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_port[i] <= 2'b00;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (win_valid[p]) begin
          rr_ptr[p] <= win_idx[p] + PW'(1);
        end else begin
          rr_ptr[p] <= rr_ptr[p];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] <= req_grant[i] & ~req_we[i];
        if (req_grant[i] & ~req_we[i]) begin
          rsp_port[i] <= req_port[2*i +: 2];
        end else begin
          rsp_port[i] <= rsp_port[i];
        end
      end
    end
  end

  // Read data arrives from the RAM one cycle after the grant
  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid[i]) begin
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data[int'(rsp_port[i])*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(0);
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [3:0]  multi;
  logic [15:0] perf_q [4];

  // Two or more candidates: clearing the lowest set bit leaves something
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      multi[p] = |(cand[p] & (cand[p] - NUM_REQ'(1)));
    end
  end

  // Saturating conflict counters, clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        perf_q[p] <= 16'h0000;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (perf_clr) begin
          perf_q[p] <= 16'h0000;
        end else if (multi[p] && (perf_q[p] != 16'hFFFF)) begin
          perf_q[p] <= perf_q[p] + 16'h0001;
        end else begin
          perf_q[p] <= perf_q[p];
        end
      end
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      perf_cnt[p*16 +: 16] = perf_q[p];
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_cnt        = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a one-cycle sync-RAM model.
module tb_mem_port_arbiter;
  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 64;
`ifdef MEM_ARB_PERF_CNT_EN
  localparam logic [15:0] PERF5 = 16'd5;
`else
  localparam logic [15:0] PERF5 = 16'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_we, req_grant, rsp_valid;
  logic [2*NR-1:0]   req_port;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata, rsp_data;
  logic [4*AW-1:0]   mem_addr;
  logic [3:0]        mem_wr_en;
  logic [4*DW-1:0]   mem_wr_data, mem_rd_data;
  logic              perf_clr;
  logic [63:0]       perf_cnt;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_port(req_port),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .perf_clr(perf_clr), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int p, input logic [11:0] a);
    return {16'hC0DE, 8'(p), 28'h0, a};
  endfunction

  // Sync RAM model: read data tagged with port and address, one cycle late
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) mem_rd_data[p*DW +: DW] <= pat(p, mem_addr[p*AW +: AW]);
  end

  int total = 0;
  int bad = 0;
  logic [11:0] addr_tab [4];
  logic [63:0] wd_tab [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [7:0] pt);
    req_valid = v;
    req_we    = w;
    req_port  = pt;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = addr_tab[i];
      req_wdata[i*DW +: DW] = wd_tab[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] we;
    logic [7:0] port;
    logic [3:0] grant;
    logic [3:0] wr_en;
  } vec_t;
  vec_t vecs [8];

  logic [11:0] ea;
  logic [63:0] ed;
  logic [3:0]  erv;
  logic [3:0]  order [6];

  initial begin
    vecs[0] = '{4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0000};
    vecs[1] = '{4'b1111, 4'b0000, 8'hE4, 4'b1111, 4'b0000};
    vecs[2] = '{4'b0010, 4'b0010, 8'h0C, 4'b0010, 4'b1000};
    vecs[3] = '{4'b0011, 4'b0000, 8'h00, 4'b0010, 4'b0000};
    vecs[4] = '{4'b0011, 4'b0000, 8'h00, 4'b0001, 4'b0000};
    vecs[5] = '{4'b1100, 4'b1000, 8'hF0, 4'b0100, 4'b0000};
    vecs[6] = '{4'b1100, 4'b1000, 8'hF0, 4'b1000, 4'b1000};
    vecs[7] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    addr_tab = '{12'h010, 12'h05A, 12'h200, 12'h3FF};
    wd_tab   = '{64'h1111_2222_3333_4444, 64'hDEAD_BEEF_0000_0001,
                 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    rst = 1'b1;
    perf_clr = 1'b0;
    drive(4'b0000, 4'b0000, 8'h00);
    do_reset();

    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_grant", 64'(req_grant), 64'h0);
    chk("reset_wr_en", 64'(mem_wr_en), 64'h0);
    chk("reset_perf", perf_cnt, 64'h0);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      drive(vecs[v].valid, vecs[v].we, vecs[v].port);
      #1;
      chk($sformatf("v%0d_grant", v), 64'(req_grant), 64'(vecs[v].grant));
      chk($sformatf("v%0d_wr_en", v), 64'(mem_wr_en), 64'(vecs[v].wr_en));
      for (int p = 0; p < 4; p++) begin
        ea = 12'h000;
        ed = 64'h0;
        for (int i = 0; i < NR; i++) begin
          if (vecs[v].grant[i] && (vecs[v].port[2*i +: 2] == 2'(p))) begin
            ea = addr_tab[i];
            ed = wd_tab[i];
          end
        end
        chk($sformatf("v%0d_addr_p%0d", v, p), 64'(mem_addr[p*AW +: AW]), 64'(ea));
        chk($sformatf("v%0d_wdata_p%0d", v, p), mem_wr_data[p*DW +: DW], ed);
      end
      @(posedge clk);
      #1;
      erv = vecs[v].grant & ~vecs[v].we;
      chk($sformatf("v%0d_rsp_valid", v), 64'(rsp_valid), 64'(erv));
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("v%0d_rsp_data%0d", v, i), rsp_data[i*DW +: DW],
            erv[i] ? pat(int'(vecs[v].port[2*i +: 2]), addr_tab[i]) : 64'h0);
      end
    end

    // Conflict and wrap on port 0 from a fresh reset
    do_reset();
    drive(4'b1111, 4'b0000, 8'h00);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_grant_c%0d", c), 64'(req_grant), 64'(order[c]));
      @(negedge clk);
    end
    drive(4'b0000, 4'b0000, 8'h00);

    // Back-to-back reads from one requester with changing address
    @(negedge clk);
    drive(4'b0001, 4'b0000, 8'h02);
    @(posedge clk);
    @(negedge clk);
    addr_tab[0] = 12'h011;
    drive(4'b0001, 4'b0000, 8'h02);
    #1;
    chk("b2b_valid1", 64'(rsp_valid), 64'h1);
    chk("b2b_data1", rsp_data[DW-1:0], pat(2, 12'h010));
    @(posedge clk);
    #1;
    chk("b2b_valid2", 64'(rsp_valid), 64'h1);
    chk("b2b_data2", rsp_data[DW-1:0], pat(2, 12'h011));
    @(negedge clk);
    addr_tab[0] = 12'h010;
    drive(4'b0000, 4'b0000, 8'h00);
    @(posedge clk);
    #1;
    chk("b2b_drop_valid", 64'(rsp_valid), 64'h0);
    chk("b2b_drop_data", rsp_data[DW-1:0], 64'h0);

    // Reset mid-operation: move port 1 pointer, issue a read, then reset
    @(negedge clk);
    drive(4'b0010, 4'b0000, 8'h04);
    @(negedge clk);
    drive(4'b0001, 4'b0000, 8'h02);
    @(posedge clk);
    #1;
    chk("mid_rsp_before_rst", 64'(rsp_valid), 64'h1);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 8'h00);
    rst = 1'b1;
    #1;
    chk("mid_rsp_in_rst", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1001, 4'b0000, 8'h41);
    #1;
    chk("mid_grant_first", 64'(req_grant), 64'h1);
    @(negedge clk);
    #1;
    chk("mid_grant_second", 64'(req_grant), 64'h8);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 8'h00);

    // Conflict counters: three requesters on port 1 for five cycles
    do_reset();
    drive(4'b0111, 4'b0000, 8'h15);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 8'h00);
    #1;
    chk("perf_p0", 64'(perf_cnt[15:0]), 64'h0);
    chk("perf_p1", 64'(perf_cnt[31:16]), 64'(PERF5));
    chk("perf_p23", 64'(perf_cnt[63:32]), 64'h0);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("perf_clr", perf_cnt, 64'h0);
    @(negedge clk);
    perf_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
